// File: rtl/fp32_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : fp32_pkg                                                 |
// | Description : Shared binary32 constants and operand classification    |
// |               for the floating-point datapath blocks.                 |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
package fp32_pkg;

    localparam int BIAS   = 127;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam logic RM_RZ  = 1'b0;
    localparam logic RM_RNE = 1'b1;

    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        NORMAL  = 2'd1,
        OVF     = 2'd2,
        NAN_INF = 2'd3
    } fp_class_t;

endpackage
`default_nettype wire

// File: rtl/rshift_sticky32.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : rshift_sticky32                                          |
// | Description : Combinational 32-bit right barrel shifter that also     |
// |               reports the guard bit and sticky OR of lost bits.       |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module rshift_sticky32 (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout,
    output logic        guard,
    output logic        sticky
);

    logic [31:0] w_lost_mask;
    logic [4:0]  w_gidx;

    // w_lost_mask covers every bit that falls off; the top one is the guard.
    assign w_lost_mask = ~(32'hFFFF_FFFF << amt);
    assign w_gidx      = amt - 5'd1;
    assign dout        = din >> amt;
    assign guard       = (amt != 5'd0) && din[w_gidx];
    assign sticky      = |(din & (w_lost_mask >> 1));

endmodule
`default_nettype wire

// File: rtl/fp32_to_int32.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : fp32_to_int32                                            |
// | Description : Three-stage binary32 to signed int32 converter with     |
// |               valid/ready backpressure, RZ/RNE rounding and flags.    |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module fp32_to_int32
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_inexact
);

    localparam logic [7:0] C_SHIFT_REF = 8'(BIAS + FRAC_W);   // E where e = 23
    localparam logic [7:0] C_OVF_EXP   = 8'(BIAS + 31);
    localparam logic [7:0] C_EXP_MAX   = 8'hFF;

    logic w_adv1, w_adv2, w_adv3;

    // ---------------- S1: unpack and classify ----------------
    logic                w_s;
    logic [EXP_W-1:0]    w_exp;
    logic [FRAC_W-1:0]   w_frac;
    logic                w_minint;
    logic [7:0]          w_ldist, w_rdist;
    fp_class_t           w_cls;
    logic                w_left;
    logic [4:0]          w_sh;

    logic        r_v1, r_s1, r_rm1, r_fnz1, r_left1;
    fp_class_t   r_cls1;
    logic [23:0] r_m1;
    logic [4:0]  r_sh1;

    assign w_s      = in_data[31];
    assign w_exp    = in_data[30:23];
    assign w_frac   = in_data[22:0];
    // -2^31 is representable; it rides the left-shift path as 1 << 31.
    assign w_minint = w_s && (w_exp == C_OVF_EXP) && (w_frac == '0);
    assign w_ldist  = w_exp - C_SHIFT_REF;
    assign w_rdist  = C_SHIFT_REF - w_exp;
    assign w_left   = (w_exp >= C_SHIFT_REF);

    always_comb begin
        w_cls = NORMAL;
        if (w_exp == C_EXP_MAX)
            w_cls = NAN_INF;
        else if (w_exp == '0)
            w_cls = ZERO;
        else if (w_exp >= C_OVF_EXP && !w_minint)
            w_cls = OVF;

        w_sh = 5'd0;
        if (w_left)
            w_sh = w_ldist[4:0];
        else if (w_rdist > 8'd31)
            w_sh = 5'd31;          // everything is shifted out either way
        else
            w_sh = w_rdist[4:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (w_adv1) begin
            r_v1    <= in_valid;
            r_s1    <= w_s;
            r_rm1   <= in_rm;
            r_fnz1  <= (w_frac != '0);
            r_left1 <= w_left;
            r_cls1  <= w_cls;
            r_m1    <= {1'b1, w_frac};
            r_sh1   <= w_sh;
        end
    end

    // ---------------- S2: shift, guard, sticky ----------------
    logic [31:0] w_rmag, w_lmag;
    logic        w_rg, w_rst;

    logic        r_v2, r_s2, r_rm2, r_fnz2, r_g2, r_st2;
    fp_class_t   r_cls2;
    logic [31:0] r_mag2;

    rshift_sticky32 u_rshift (
        .din    ({8'd0, r_m1}),
        .amt    (r_sh1),
        .dout   (w_rmag),
        .guard  (w_rg),
        .sticky (w_rst)
    );

    assign w_lmag = {8'd0, r_m1} << r_sh1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2   <= r_v1;
            r_s2   <= r_s1;
            r_rm2  <= r_rm1;
            r_fnz2 <= r_fnz1;
            r_cls2 <= r_cls1;
            r_mag2 <= r_left1 ? w_lmag : w_rmag;
            r_g2   <= r_left1 ? 1'b0 : w_rg;
            r_st2  <= r_left1 ? 1'b0 : w_rst;
        end
    end

    // ---------------- S3: round, negate, saturate ----------------
    logic        w_inc;
    logic [31:0] w_mag_r, w_sres;
    logic [31:0] w_data;
    logic        w_inv, w_inx;

    assign w_inc   = (r_rm2 == RM_RNE) && r_g2 && (r_st2 || r_mag2[0]);
    assign w_mag_r = r_mag2 + {31'd0, w_inc};
    assign w_sres  = r_s2 ? (32'd0 - w_mag_r) : w_mag_r;

    always_comb begin
        w_data = 32'd0;
        w_inv  = 1'b0;
        w_inx  = 1'b0;
        case (r_cls2)
            NORMAL: begin
                w_data = w_sres;
                w_inx  = r_g2 | r_st2;
            end
            ZERO: begin
                w_inx = r_fnz2;
            end
            OVF: begin
                w_data = r_s2 ? INT_MIN : INT_MAX;
                w_inv  = 1'b1;
            end
            NAN_INF: begin
                // NaN of either sign maps to INT_MIN, like -inf
                w_data = (r_fnz2 || r_s2) ? INT_MIN : INT_MAX;
                w_inv  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else if (w_adv3) begin
            out_valid   <= r_v2;
            out_data    <= w_data;
            out_invalid <= w_inv;
            out_inexact <= w_inx;
        end
    end

    // ---------------- handshake ----------------
    assign w_adv3   = !out_valid | out_ready;
    assign w_adv2   = !r_v2 | w_adv3;
    assign w_adv1   = !r_v1 | w_adv2;
    assign in_ready = w_adv1 | rst;

endmodule
`default_nettype wire

// File: doc/fp32_to_int32.md
# fp32_to_int32

Pipelined single-precision-to-signed-32-bit-integer converter for the floating-point datapath. It is the inverse of the adder's normalize path. Where the adder uses a leading-one encoder to turn an integer magnitude into a shift count, this block uses the exponent as a shift count to expand a normalized significand back into a two's-complement integer. It accepts one operand per cycle through a valid/ready handshake and has three register stages with full backpressure.

## Interface
- No parameters. Widths are fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand present
- in_ready  out  1  block can accept the operand this cycle
- in_data  in  32  IEEE-754 binary32 operand
- in_rm  in  1  rounding mode: 0 = toward zero, 1 = nearest-even
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  32  signed integer result
- out_invalid  out  1  NaN, infinity or out-of-range operand
- out_inexact  out  1  result differs from the operand value (not set when out_invalid is set)

## Operation
- Unpack the operand: s = bit 31, E = bits 30:23, f = bits 22:0, m = {1, f} (24 bits), e = E − 127.
- Classify:
  - E = 255 (NaN or infinity) → invalid. Result is 0x80000000 for NaN, 0x7FFFFFFF for +inf, 0x80000000 for −inf.
  - E = 0 (zero or subnormal) → result 0. Inexact when f ≠ 0.
  - e ≥ 31 → overflow, with one exception: s = 1, e = 31, f = 0 is exactly −2^31 and gives 0x80000000 with no flags. Otherwise invalid, and the result saturates to 0x7FFFFFFF if s = 0, or 0x80000000 if s = 1.
  - 23 ≤ e ≤ 30 → magnitude = m << (e − 23). Exact.
  - 0 ≤ e ≤ 22 → magnitude = m >> (23 − e). Guard = the last bit shifted out; sticky = OR of the remaining shifted-out bits.
  - e < 0 → magnitude 0. Guard = 1 if e = −1, else 0. Sticky = 1 if e < −1, or if (e = −1 and f ≠ 0).
- Rounding:
  - rm = 0: truncate.
  - rm = 1: increment when guard & (sticky | magnitude[0]).
  - inexact = guard | sticky.
- Post-round overflow cannot occur, because the largest in-range magnitude (e = 30, rounded) is below 2^31.
- Sign: the result is the two's complement of the magnitude when s = 1. A result of −0 becomes 0.
- in_rm travels with its operand and is never sampled late.

## Timing
- Three stages:
  - S1: unpack, classify, compute shift amount and direction.
  - S2: shift, compute guard and sticky.
  - S3: round, negate, saturate, register flags.
- Latency is 3 cycles from in_valid & in_ready to out_valid, with no bubbles when out_ready stays high. Throughput is 1 per cycle.
- Each stage has a valid bit. A stage advances when it is empty or the stage after it advances. in_ready = !v1 | advance1. This is purely combinational from out_ready and the valid bits.
- out_data, out_invalid and out_inexact hold stable while out_valid & !out_ready.
- Results leave in the same order the operands arrived. No operand is dropped or duplicated.
- Reset:
  - All stage valid bits and all outputs are 0 on the cycle after rst is sampled high.
  - in_ready is 1 during and after reset.
  - Operands in flight when rst asserts are discarded.
  - A handshake on the same cycle as rst is ignored.
- Simultaneous events: the pipeline accepts a new operand and emits a result in the same cycle whenever it is full and out_ready = 1.

## Structure
- Shared package fp32_pkg holds:
  - BIAS = 127, EXP_W = 8, FRAC_W = 23.
  - INT_MAX = 32'h7FFFFFFF, INT_MIN = 32'h80000000.
  - RM_RZ = 1'b0, RM_RNE = 1'b1.
  - The classify encoding: ZERO, NORMAL, OVF, NAN_INF.
- The adder and subtracter will share this package.
- One sub-module, rshift_sticky32:
  - Combinational 32-bit right barrel shifter.
  - Inputs: 5-bit shift amount.
  - Outputs: shifted value, guard and sticky.
  - Instantiated in S2.
- The left-shift path is handled inline.

## Test plan
- 0x406CCCCD (3.7): rm = 0 → 3, inexact 1. rm = 1 → 4, inexact 1.
- 0x40200000 (2.5), rm = 1 → 2. 0x40600000 (3.5), rm = 1 → 4. 0xBFC00000 (−1.5), rm = 1 → 0xFFFFFFFE. All inexact.
- Boundary values:
  - 0xCF000000 → 0x80000000, both flags 0.
  - 0x4F000000 → 0x7FFFFFFF, invalid.
  - 0x7FC00000 → 0x80000000, invalid.
  - 0x80000000 → 0, no flags.
  - 0x3F000000 (0.5), rm = 1 → 0, inexact.
- Backpressure:
  - Stimulus: hold out_ready = 0, push 5 back-to-back operands.
  - in_ready drops after 3 are accepted.
  - After releasing out_ready, all 5 results appear in order on consecutive cycles.
- Reset with 3 operands in flight: out_valid is 0 the next cycle and no stale result ever appears. A fresh operand 0x41200000 (10.0) returns 10 exactly 3 cycles after acceptance.
